// File: rtl/adder_pkg.sv
// Shared definitions for the segmented pipelined adder: operation encoding,
// pipeline depth helper and the default segment width.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int DEFAULT_SEG = 4;

  // Pipeline depth (and latency in cycles) for a given width/segment pair.
  function automatic int calc_stages(input int width, input int seg);
    return width / seg;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full-adder cell; the building block of every ripple segment.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/seg_ripple_adder.sv
// Combinational SEG-bit ripple-carry chain built from full_adder cells.
// One instance resolves one segment of the wide add in a single stage.
module seg_ripple_adder
  import adder_pkg::*;
#(
  parameter int SEG = DEFAULT_SEG
) (
  input  logic [SEG-1:0] x,
  input  logic [SEG-1:0] y,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           cout
);

  logic [SEG:0] w_carry;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < SEG; i++) begin : g_bit
    full_adder u_fa (
      .a  (x[i]),
      .b  (y[i]),
      .ci (w_carry[i]),
      .s  (s[i]),
      .co (w_carry[i+1])
    );
  end

  assign cout = w_carry[SEG];

endmodule

// File: rtl/pipelined_segment_adder.sv
// Pipelined WIDTH-bit add/subtract built from SEG-bit ripple segments, one
// segment per stage with the carry registered between stages.
// Optional macro PIPELINED_SEGMENT_ADDER_OVF_EN adds the registered signed
// overflow output 'ovf'.
//
// Handshake: a beat is accepted when in_valid & in_ready; a result is taken
// when out_valid & out_ready. The whole pipe advances together when
// adv = out_ready | ~out_valid (in_ready = adv); on adv=0 every stage holds,
// so s/cout stay stable while a result waits. Bubbles are not collapsed.
module pipelined_segment_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = DEFAULT_SEG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef PIPELINED_SEGMENT_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STAGES = calc_stages(WIDTH, SEG);

  if (WIDTH % SEG != 0) begin : g_bad_params
    $error("pipelined_segment_adder: WIDTH must be a multiple of SEG");
  end

  logic             w_adv;
  op_e              w_op;
  logic [WIDTH-1:0] w_yy;
  logic             w_c0;

  // Subtract is x + ~y + 1, so the carry-in is forced high and cin ignored.
  assign w_op     = op_e'(sub);
  assign w_yy     = (w_op == OP_SUB) ? ~y : y;
  assign w_c0     = (w_op == OP_SUB) ? 1'b1 : cin;
  assign w_adv    = out_ready | ~out_valid;
  assign in_ready = w_adv;

  // Unprocessed upper segments of the effective B operand. Entry j holds what
  // is still needed after stage j, right-aligned so the next segment sits in
  // the low SEG bits; each entry is exactly as wide as what remains.
  for (genvar j = 0; j < STAGES - 1; j++) begin : g_yreg
    localparam int YW = WIDTH - (j + 1) * SEG;
    logic [YW-1:0] r_yr;
    logic [YW-1:0] w_yr_d;

    if (j == 0) begin : g_src_in
      assign w_yr_d = w_yy[WIDTH-1:SEG];
    end else begin : g_src_prev
      assign w_yr_d = g_yreg[j-1].r_yr[YW+SEG-1:SEG];
    end

    // Carry the remaining B segments forward one stage per advance.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_yr <= '0;
      end else if (w_adv) begin
        r_yr <= w_yr_d;
      end
    end
  end

  // Stage k resolves segment k. r_xs packs the finished lower sum segments
  // (bits below (k+1)*SEG) with the still-unprocessed upper A segments, so
  // after the last stage it is exactly the full result.
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic [WIDTH-1:0] w_cur;
    logic [WIDTH-1:0] w_nxt;
    logic [SEG-1:0]   w_xa;
    logic [SEG-1:0]   w_ya;
    logic [SEG-1:0]   w_sa;
    logic             w_ci;
    logic             w_co;
    logic             w_vin;
    logic             r_v;
    logic             r_c;
    logic [WIDTH-1:0] r_xs;

    if (k == 0) begin : g_head
      assign w_cur = x;
      assign w_ya  = w_yy[SEG-1:0];
      assign w_ci  = w_c0;
      assign w_vin = in_valid;
    end else begin : g_body
      assign w_cur = g_stg[k-1].r_xs;
      assign w_ya  = g_yreg[k-1].r_yr[SEG-1:0];
      assign w_ci  = g_stg[k-1].r_c;
      assign w_vin = g_stg[k-1].r_v;
    end

    assign w_xa = w_cur[k*SEG +: SEG];

    seg_ripple_adder #(
      .SEG (SEG)
    ) u_seg (
      .x    (w_xa),
      .y    (w_ya),
      .cin  (w_ci),
      .s    (w_sa),
      .cout (w_co)
    );

    // Replace the consumed A segment with its freshly computed sum segment.
    always_comb begin
      w_nxt               = w_cur;
      w_nxt[k*SEG +: SEG] = w_sa;
    end

    // Stage register: valid bit, carry-out and packed sum/operand word.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v  <= 1'b0;
        r_c  <= 1'b0;
        r_xs <= '0;
      end else if (w_adv) begin
        r_v  <= w_vin;
        r_c  <= w_co;
        r_xs <= w_nxt;
      end
    end
  end

  assign out_valid = g_stg[STAGES-1].r_v;
  assign s         = g_stg[STAGES-1].r_xs;
  assign cout      = g_stg[STAGES-1].r_c;

`ifdef PIPELINED_SEGMENT_ADDER_OVF_EN
  logic w_cmsb;
  logic w_ovf_d;
  logic r_ovf;

  // Carry into the MSB recovered from the MSB sum bit: c = a ^ b ^ s.
  assign w_cmsb  = g_stg[STAGES-1].w_xa[SEG-1] ^ g_stg[STAGES-1].w_ya[SEG-1]
                 ^ g_stg[STAGES-1].w_sa[SEG-1];
  assign w_ovf_d = w_cmsb ^ g_stg[STAGES-1].w_co;

  // Signed overflow registered alongside the final stage so it tracks s.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      r_ovf <= w_ovf_d;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_pipelined_segment_adder.sv
// Testbench for pipelined_segment_adder: 16/4 instance with a decoupled
// scoreboard plus an 8/8 single-stage instance. Build with
// +define+PIPELINED_SEGMENT_ADDER_OVF_EN to also check ovf.
module tb_pipelined_segment_adder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT 16/4 ----------------
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s;
  logic        cout;
`ifdef PIPELINED_SEGMENT_ADDER_OVF_EN
  logic        ovf;
`endif

  pipelined_segment_adder #(.WIDTH(16), .SEG(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout)
`ifdef PIPELINED_SEGMENT_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // ---------------- DUT 8/8 (single stage) ----------------
  logic       b_in_valid;
  logic       b_in_ready;
  logic [7:0] b_x;
  logic [7:0] b_y;
  logic       b_cin;
  logic       b_sub;
  logic       b_out_valid;
  logic       b_out_ready;
  logic [7:0] b_s;
  logic       b_cout;
`ifdef PIPELINED_SEGMENT_ADDER_OVF_EN
  logic       b_ovf;
`endif

  pipelined_segment_adder #(.WIDTH(8), .SEG(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .x         (b_x),
    .y         (b_y),
    .cin       (b_cin),
    .sub       (b_sub),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .s         (b_s),
    .cout      (b_cout)
`ifdef PIPELINED_SEGMENT_ADDER_OVF_EN
    ,
    .ovf       (b_ovf)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [17:0] exp_q[$];   // {ovf, cout, s}
  int n_checks = 0;
  int n_pass   = 0;
  int stall_cnt = 0;
  bit hold_ready = 1'b0;
  bit rand_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: plain integer arithmetic on the operands' numeric values.
  function automatic void ref_op(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic c, input logic sb,
                                 output logic [15:0] rs, output logic rc, output logic ro);
    longint full, half, ua, ub, sa, sbv, r, sr;
    full = longint'(1) << w;
    half = full >> 1;
    ua   = longint'(a) & (full - 1);
    ub   = longint'(b) & (full - 1);
    sa   = (ua >= half) ? ua - full : ua;
    sbv  = (ub >= half) ? ub - full : ub;
    if (sb) begin
      r  = ua - ub + full;
      rc = (ua >= ub);
      sr = sa - sbv;
    end else begin
      r  = ua + ub + longint'(c);
      rc = (r >= full);
      sr = sa + sbv + longint'(c);
    end
    rs = 16'(r & (full - 1));
    ro = (sr > half - 1) || (sr < -half);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input logic [15:0] a, input logic [15:0] b,
                            input logic c, input logic sb);
    int waited;
    logic [15:0] rs;
    logic rc, ro;
    waited = 0;
    @(negedge clk);
    x = a; y = b; cin = c; sub = sb; in_valid = 1'b1;
    #1;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles, expected 1", waited);
    end else begin
      ref_op(16, a, b, c, sb, rs, rc, ro);
      exp_q.push_back({ro, rc, rs});
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue", exp_q.size(), 0);
  endtask

  // ---------------- sink: drives out_ready ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (hold_ready) out_ready = 1'b0;
      else if (stall_cnt > 0) begin
        out_ready = 1'b0;
        stall_cnt--;
      end else if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      else out_ready = 1'b1;
    end
  end

  // ---------------- monitor ----------------
  initial begin
    bit          held;
    logic [16:0] held_val;
    logic [17:0] e;
    held = 1'b0;
    held_val = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        held = 1'b0;
        continue;
      end
      if (held) begin
        chk("stall_hold_valid", out_valid, 1);
        chk("stall_hold_data", {cout, s}, held_val);
      end
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", in_ready, 0);
        held = 1'b1;
        held_val = {cout, s};
      end else begin
        held = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: got s=0x%0h cout=%0b, expected no result", s, cout);
        end else begin
          e = exp_q.pop_front();
          chk("result", {cout, s}, e[16:0]);
`ifdef PIPELINED_SEGMENT_ADDER_OVF_EN
          chk("result_ovf", ovf, e[17]);
`endif
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0]  va[5];
    logic [7:0]  vb[5];
    logic        vc[5];
    logic        vs[5];
    logic [15:0] rs;
    logic        rc, ro;

    rst_n = 1'b0;
    in_valid = 1'b0; x = '0; y = '0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b1;
    b_in_valid = 1'b0; b_x = '0; b_y = '0; b_cin = 1'b0; b_sub = 1'b0;
    b_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_s", s, 0);
    chk("reset_cout", cout, 0);
    chk("reset_in_ready", in_ready, 1);
`ifdef PIPELINED_SEGMENT_ADDER_OVF_EN
    chk("reset_ovf", ovf, 0);
`endif

    // Directed patterns: basic add, full wrap, subtracts, signed overflow.
    drive_beat(16'h1234, 16'h0FFF, 1'b0, 1'b0);
    drive_beat(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    drive_beat(16'h0005, 16'h0007, 1'b0, 1'b1);
    drive_beat(16'h8000, 16'h8000, 1'b0, 1'b1);
    drive_beat(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    drive_beat(16'h0010, 16'h0003, 1'b1, 1'b1);
    drive_beat(16'h00FF, 16'h0F00, 1'b1, 1'b0);
    idle();
    wait_drain();

    // Eight back-to-back beats with a 3-cycle output stall mid-stream.
    for (int i = 0; i < 8; i++) begin
      if (i == 4) stall_cnt = 3;
      drive_beat(16'(i), 16'(i * 3), 1'b0, 1'b0);
    end
    idle();
    wait_drain();

    // Randomised traffic with random back-pressure and input gaps.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [15:0] ra, rb;
      if ($urandom_range(0, 4) == 0) idle();
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 7) == 0) rb = ra;
      if ($urandom_range(0, 7) == 0) ra = 16'hFFFF;
      drive_beat(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    idle();
    wait_drain();
    rand_ready = 1'b0;

    // Reset with results in flight and one waiting at the output.
    hold_ready = 1'b1;
    drive_beat(16'h1111, 16'h2222, 1'b0, 1'b0);
    drive_beat(16'h3333, 16'h4444, 1'b0, 1'b0);
    drive_beat(16'h5555, 16'h6666, 1'b0, 1'b0);
    idle();
    repeat (6) @(negedge clk);
    #2;
    chk("pre_reset_out_valid", out_valid, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", out_valid, 0);
    chk("async_reset_s", s, 0);
    chk("async_reset_cout", cout, 0);
    exp_q.delete();
    hold_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    drive_beat(16'hABCD, 16'h1234, 1'b0, 1'b1);
    drive_beat(16'h0001, 16'hFFFF, 1'b1, 1'b0);
    idle();
    wait_drain();

    // Single-stage instance: result one cycle after acceptance.
    va[0] = 8'hFF; vb[0] = 8'h01; vc[0] = 1'b0; vs[0] = 1'b0;
    va[1] = 8'h05; vb[1] = 8'h07; vc[1] = 1'b0; vs[1] = 1'b1;
    va[2] = 8'h7F; vb[2] = 8'h01; vc[2] = 1'b0; vs[2] = 1'b0;
    va[3] = 8'h80; vb[3] = 8'h80; vc[3] = 1'b1; vs[3] = 1'b1;
    va[4] = 8'h3C; vb[4] = 8'h44; vc[4] = 1'b1; vs[4] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      b_x = va[i]; b_y = vb[i]; b_cin = vc[i]; b_sub = vs[i]; b_in_valid = 1'b1;
      #1;
      chk("w8_in_ready", b_in_ready, 1);
      @(negedge clk);
      #2;
      ref_op(8, {8'h00, va[i]}, {8'h00, vb[i]}, vc[i], vs[i], rs, rc, ro);
      chk("w8_out_valid", b_out_valid, 1);
      chk("w8_result", {b_cout, b_s}, {rc, rs[7:0]});
`ifdef PIPELINED_SEGMENT_ADDER_OVF_EN
      chk("w8_ovf", b_ovf, ro);
`endif
      b_in_valid = 1'b0;
    end
    @(negedge clk);
    #2;
    chk("w8_idle_out_valid", b_out_valid, 0);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
